// File: rtl/dzcpu_ucode_sequencer_pkg.sv
// Shared definitions for the dzcpu microcode sequencer: flow codes, the JCB escape op,
// uop field slices and the sequencer state encoding.
package dzcpu_ucode_sequencer_pkg;

  localparam logic [3:0] FLOW_OP           = 4'd0;
  localparam logic [3:0] FLOW_INC          = 4'd1;
  localparam logic [3:0] FLOW_EOF          = 4'd2;
  localparam logic [3:0] FLOW_INC_EOF      = 4'd3;
  localparam logic [3:0] FLOW_EOF_FU       = 4'd4;
  localparam logic [3:0] FLOW_INC_EOF_FU   = 4'd5;
  localparam logic [3:0] FLOW_INC_EOF_Z    = 4'd6;
  localparam logic [3:0] FLOW_INC_EOF_NZ   = 4'd7;
  localparam logic [3:0] FLOW_UPDATE_FLAGS = 4'd8;
  localparam logic [3:0] FLOW_NOP          = 4'd9;

  // Escape to the 0xCB table: next uPC comes from the CB LUT for the byte on the bus.
  localparam logic [4:0] OP_JCB = 5'h1f;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_EXEC   = 2'd2
  } state_e;

  typedef struct packed {
    logic advance;
    logic fin;
    logic inc_pc;
    logic update_flags;
  } flow_ctl_t;

  function automatic logic [3:0] uop_flow(input logic [12:0] uop);
    return uop[12:9];
  endfunction

  function automatic logic [4:0] uop_op(input logic [12:0] uop);
    return uop[8:4];
  endfunction

  function automatic logic [3:0] uop_operand(input logic [12:0] uop);
    return uop[3:0];
  endfunction

endpackage

// File: rtl/dzcpu_ucode_sequencer_flow_decode.sv
// Combinational decode of a uop flow field plus Z flag into sequencing controls.
module dzcpu_ucode_sequencer_flow_decode
  import dzcpu_ucode_sequencer_pkg::*;
(
  input  logic [3:0] flow,
  input  logic       flag_z,
  output flow_ctl_t  ctl
);

  always_comb begin
    ctl = '0;
    case (flow)
      FLOW_OP, FLOW_NOP: ctl.advance = 1'b1;
      FLOW_INC: begin
        ctl.advance = 1'b1;
        ctl.inc_pc  = 1'b1;
      end
      FLOW_UPDATE_FLAGS: begin
        ctl.advance      = 1'b1;
        ctl.update_flags = 1'b1;
      end
      FLOW_EOF: ctl.fin = 1'b1;
      FLOW_INC_EOF: begin
        ctl.fin    = 1'b1;
        ctl.inc_pc = 1'b1;
      end
      FLOW_EOF_FU: begin
        ctl.fin          = 1'b1;
        ctl.update_flags = 1'b1;
      end
      FLOW_INC_EOF_FU: begin
        ctl.fin          = 1'b1;
        ctl.inc_pc       = 1'b1;
        ctl.update_flags = 1'b1;
      end
      FLOW_INC_EOF_Z: begin
        ctl.inc_pc  = 1'b1;
        ctl.fin     = flag_z;
        ctl.advance = ~flag_z;
      end
      FLOW_INC_EOF_NZ: begin
        ctl.inc_pc  = 1'b1;
        ctl.fin     = ~flag_z;
        ctl.advance = flag_z;
      end
      // Unassigned codes behave like nop so a stray ROM word cannot wedge the sequencer.
      default: ctl.advance = 1'b1;
    endcase
  end

endmodule

// File: rtl/dzcpu_ucode_sequencer.sv
// dzcpu microcode sequencer: decodes opcodes via external flow LUTs and walks the
// microcode ROM one uop per cycle, emitting uop fields and PC/flag strobes.
module dzcpu_ucode_sequencer
  import dzcpu_ucode_sequencer_pkg::*;
#(
  parameter int               UPC_W     = 8,
  parameter logic [UPC_W-1:0] RESET_UPC = '0
) (
  input  logic             iClock,
  input  logic             iReset,
  input  logic [7:0]       iMemData,
  output logic [7:0]       oMop,
  input  logic [UPC_W-1:0] iFlowIdx,
  input  logic [UPC_W-1:0] iCbFlowIdx,
  output logic [UPC_W-1:0] oUopAddr,
  input  logic [12:0]      iUop,
  input  logic             iFlagZ,
  input  logic             iStall,
  input  logic             iIrqReq,
  input  logic [UPC_W-1:0] iIrqFlowIdx,
  output logic             oIrqAck,
  output logic             oUopValid,
  output logic [4:0]       oOp,
  output logic [3:0]       oOperand,
  output logic             oIncPc,
  output logic             oUpdateFlags,
  output logic             oEof,
  output logic [1:0]       oDbgState
);

  // Handshake: the sequencer never waits on the datapath. A uop is issued on every cycle
  // where oUopValid=1; iStall=1 suppresses issue and freezes all state, so a stalled uop
  // is re-presented unchanged on the first cycle iStall drops.

  state_e           state;
  logic [UPC_W-1:0] upc;
  logic [7:0]       opcode;
  logic             irq_ack_q;

  flow_ctl_t        ctl;
  logic             is_exec;
  logic             is_jcb;
  logic             issue;
  logic [UPC_W-1:0] next_upc;

  dzcpu_ucode_sequencer_flow_decode u_flow_decode (
    .flow   (uop_flow(iUop)),
    .flag_z (iFlagZ),
    .ctl    (ctl)
  );

  assign is_exec  = (state == ST_EXEC);
  assign is_jcb   = is_exec && (uop_op(iUop) == OP_JCB);
  assign issue    = is_exec && !iStall;
  assign next_upc = (upc == {UPC_W{1'b1}}) ? RESET_UPC : upc + 1'b1;

  // The CB LUT needs the byte after 0xCB in the same cycle as the JCB uop.
  assign oMop         = (state == ST_DECODE || is_jcb) ? iMemData : opcode;
  assign oUopAddr     = upc;
  assign oUopValid    = issue;
  assign oOp          = issue ? uop_op(iUop) : '0;
  assign oOperand     = issue ? uop_operand(iUop) : '0;
  assign oIncPc       = issue && ctl.inc_pc;
  assign oUpdateFlags = issue && ctl.update_flags;
  assign oEof         = issue && !is_jcb && ctl.fin;
  assign oIrqAck      = irq_ack_q && !iStall;
  assign oDbgState    = state;

  always_ff @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      state     <= ST_IDLE;
      upc       <= RESET_UPC;
      opcode    <= '0;
      irq_ack_q <= 1'b0;
    end else if (!iStall) begin
      irq_ack_q <= 1'b0;
      case (state)
        ST_IDLE: state <= ST_DECODE;
        ST_DECODE: begin
          opcode <= iMemData;
          upc    <= iFlowIdx;
          state  <= ST_EXEC;
        end
        ST_EXEC: begin
          if (is_jcb) begin
            opcode <= iMemData;
            upc    <= iCbFlowIdx;
          end else if (ctl.fin) begin
            // Interrupts are only taken at an instruction boundary, skipping DECODE.
            if (iIrqReq) begin
              upc       <= iIrqFlowIdx;
              irq_ack_q <= 1'b1;
            end else begin
              state <= ST_DECODE;
            end
          end else if (ctl.advance) begin
            upc <= next_upc;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dzcpu_ucode_sequencer.sv
// Bench for dzcpu_ucode_sequencer: LUT/ROM/memory models, program-level reference model,
// scoreboard queue of expected uops, and directed IRQ/stall/reset scenarios.
module tb_dzcpu_ucode_sequencer;

  localparam logic [3:0] F_OP = 4'd0, F_INC = 4'd1, F_EOF = 4'd2, F_INC_EOF = 4'd3;
  localparam logic [3:0] F_EOF_FU = 4'd4, F_INC_EOF_FU = 4'd5, F_INC_EOF_Z = 4'd6;
  localparam logic [3:0] F_INC_EOF_NZ = 4'd7, F_UF = 4'd8, F_NOP = 4'd9;
  localparam logic [4:0] JCB = 5'h1f;

  logic        iClock = 1'b0;
  logic        iReset = 1'b1;
  logic [7:0]  iMemData;
  logic [7:0]  oMop;
  logic [7:0]  iFlowIdx;
  logic [7:0]  iCbFlowIdx;
  logic [7:0]  oUopAddr;
  logic [12:0] iUop;
  logic        iFlagZ;
  logic        iStall = 1'b0;
  logic        iIrqReq = 1'b0;
  logic [7:0]  iIrqFlowIdx = 8'd0;
  logic        oIrqAck;
  logic        oUopValid;
  logic [4:0]  oOp;
  logic [3:0]  oOperand;
  logic        oIncPc;
  logic        oUpdateFlags;
  logic        oEof;
  logic [1:0]  oDbgState;

  logic [7:0]  mem      [256];
  logic [7:0]  main_lut [256];
  logic [7:0]  cb_lut   [256];
  logic [12:0] rom      [256];
  bit          zmem     [256];
  logic [7:0]  pc;
  int          instr_idx;

  logic [19:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  // ---------------- clock / reset ----------------
  always #5 iClock = ~iClock;

  dzcpu_ucode_sequencer dut (
    .iClock(iClock), .iReset(iReset), .iMemData(iMemData), .oMop(oMop),
    .iFlowIdx(iFlowIdx), .iCbFlowIdx(iCbFlowIdx), .oUopAddr(oUopAddr), .iUop(iUop),
    .iFlagZ(iFlagZ), .iStall(iStall), .iIrqReq(iIrqReq), .iIrqFlowIdx(iIrqFlowIdx),
    .oIrqAck(oIrqAck), .oUopValid(oUopValid), .oOp(oOp), .oOperand(oOperand),
    .oIncPc(oIncPc), .oUpdateFlags(oUpdateFlags), .oEof(oEof), .oDbgState(oDbgState)
  );

  // External LUTs, ROM and memory around the sequencer.
  assign iFlowIdx   = main_lut[oMop];
  assign iCbFlowIdx = cb_lut[oMop];
  assign iUop       = rom[oUopAddr];
  assign iMemData   = mem[pc];
  assign iFlagZ     = zmem[instr_idx[7:0]];

  always @(posedge iClock or posedge iReset) begin
    if (iReset) begin
      pc        <= 8'd0;
      instr_idx <= 0;
    end else begin
      if (oIncPc) pc <= pc + 8'd1;
      if (oEof) instr_idx <= instr_idx + 1;
    end
  end

  function automatic logic [12:0] u(input logic [3:0] fl, input logic [4:0] op, input logic [3:0] opnd);
    return {fl, op, opnd};
  endfunction

  function automatic logic [19:0] rec(input logic [7:0] a, input logic [4:0] op, input logic [3:0] opnd,
                                      input bit inc, input bit uf, input bit eof);
    return {a, op, opnd, inc, uf, eof};
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] mpc;
  int         minstr;

  task automatic model_flow(input logic [7:0] start);
    logic [7:0]  addr;
    logic [12:0] w;
    logic [3:0]  fl;
    bit          inc, uf, fin, z;
    addr = start;
    z    = zmem[minstr[7:0]];
    for (int n = 0; n < 300; n++) begin
      w   = rom[addr];
      fl  = w[12:9];
      inc = (fl == F_INC) || (fl == F_INC_EOF) || (fl == F_INC_EOF_FU) ||
            (fl == F_INC_EOF_Z) || (fl == F_INC_EOF_NZ);
      uf  = (fl == F_EOF_FU) || (fl == F_INC_EOF_FU) || (fl == F_UF);
      if (w[8:4] == JCB) begin
        exp_q.push_back(rec(addr, w[8:4], w[3:0], inc, uf, 1'b0));
        addr = cb_lut[mem[mpc]];
        if (inc) mpc = mpc + 8'd1;
        continue;
      end
      fin = (fl == F_EOF) || (fl == F_INC_EOF) || (fl == F_EOF_FU) || (fl == F_INC_EOF_FU) ||
            (fl == F_INC_EOF_Z && z) || (fl == F_INC_EOF_NZ && !z);
      exp_q.push_back(rec(addr, w[8:4], w[3:0], inc, uf, fin));
      if (inc) mpc = mpc + 8'd1;
      if (fin) break;
      addr = addr + 8'd1;
    end
    minstr++;
  endtask

  task automatic model_instr();
    model_flow(main_lut[mem[mpc]]);
  endtask

  // ---------------- program generation ----------------
  logic [7:0] gen_pc;
  int         gen_n;

  task automatic new_program();
    for (int i = 0; i < 256; i++) begin
      mem[i]  = 8'h00;
      zmem[i] = 1'b0;
    end
    gen_pc = 8'd0;
    gen_n  = 0;
    mpc    = 8'd0;
    minstr = 0;
    exp_q.delete();
  endtask

  task automatic put_byte(input logic [7:0] b);
    mem[gen_pc] = b;
    gen_pc = gen_pc + 8'd1;
  endtask

  task automatic put_instr(input int kind, input bit z);
    zmem[gen_n[7:0]] = z;
    gen_n++;
    case (kind)
      0: put_byte(8'h00);
      1: begin put_byte(8'h20); put_byte(8'($urandom_range(0, 255))); end
      2: begin put_byte(8'hCB); put_byte(8'h7C); end
      3: begin put_byte(8'hCD); put_byte(8'($urandom_range(0, 255))); put_byte(8'($urandom_range(0, 255))); end
      4: put_byte(8'h0C);
      5: begin put_byte(8'hEA); put_byte(8'($urandom_range(0, 255))); put_byte(8'($urandom_range(0, 255))); end
      6: put_byte(8'h55);
      default: put_byte(8'h77);
    endcase
  endtask

  task automatic model_program();
    for (int i = 0; i < gen_n; i++) model_instr();
  endtask

  // ---------------- driver tasks ----------------
  task automatic drain(input bit stall_en, input string name);
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 4000) begin
      @(negedge iClock);
      #1;
      iStall = stall_en ? ($urandom_range(0, 3) == 0) : 1'b0;
      cyc++;
    end
    iStall = 1'b0;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: %0d uops still expected after %0d cycles, required 0", name, exp_q.size(), cyc);
    end
  endtask

  task automatic wait_addr(input logic [7:0] a, input bit need_eof, input string name);
    int cyc;
    cyc = 0;
    do begin
      @(negedge iClock);
      #1;
      cyc++;
    end while (!(oUopValid && oUopAddr == a && (!need_eof || oEof)) && cyc < 200);
    checks++;
    if (cyc >= 200) begin
      errors++;
      $display("FAIL %s_wait: uop addr %0d never seen, last addr %0d", name, a, oUopAddr);
    end
  endtask

  task automatic start_run();
    iReset = 1'b1;
    repeat (2) @(negedge iClock);
    iReset = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  initial begin
    logic [19:0] got, want;
    forever begin
      @(negedge iClock);
      #2;
      if (oUopValid && exp_q.size() != 0) begin
        got  = {oUopAddr, oOp, oOperand, oIncPc, oUpdateFlags, oEof};
        want = exp_q.pop_front();
        checks++;
        if (got !== want) begin
          errors++;
          $display("FAIL uop: got addr=%0d op=%h opnd=%h inc=%b uf=%b eof=%b, required addr=%0d op=%h opnd=%h inc=%b uf=%b eof=%b",
                   got[19:12], got[11:7], got[6:3], got[2], got[1], got[0],
                   want[19:12], want[11:7], want[6:3], want[2], want[1], want[0]);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int kinds[8];
    bit zs[8];
    for (int i = 0; i < 256; i++) begin
      main_lut[i] = 8'd0;
      cb_lut[i]   = 8'd0;
      rom[i]      = 13'd0;
    end
    main_lut[8'h00] = 8'd162; main_lut[8'h20] = 8'd17;  main_lut[8'hCB] = 8'd13;
    main_lut[8'hCD] = 8'd48;  main_lut[8'h0C] = 8'd32;  main_lut[8'hEA] = 8'd100;
    main_lut[8'h77] = 8'd254; cb_lut[8'h7C]   = 8'd16;
    rom[0]   = u(F_INC_EOF, 5'd2, 4'd1);
    rom[13]  = u(F_INC, 5'd3, 4'd0);      rom[14]  = u(F_NOP, 5'd0, 4'd0);
    rom[15]  = u(F_INC, JCB, 4'd0);       rom[16]  = u(F_EOF_FU, 5'd5, 4'd7);
    rom[17]  = u(F_INC, 5'd4, 4'd2);      rom[18]  = u(F_OP, 5'd6, 4'd3);
    rom[19]  = u(F_INC_EOF_Z, 5'd7, 4'd4); rom[20] = u(F_OP, 5'd8, 4'd5);
    rom[21]  = u(F_OP, 5'd9, 4'd6);       rom[22]  = u(F_EOF, 5'd10, 4'd0);
    rom[32]  = u(F_UF, 5'd11, 4'd1);      rom[33]  = u(F_INC_EOF, 5'd12, 4'd1);
    rom[48]  = u(F_INC, 5'd13, 4'd0);     rom[49]  = u(F_OP, 5'd14, 4'd1);
    rom[50]  = u(F_INC, 5'd13, 4'd2);     rom[51]  = u(F_OP, 5'd14, 4'd3);
    rom[52]  = u(F_INC, 5'd15, 4'd4);     rom[53]  = u(F_EOF, 5'd16, 4'd0);
    rom[100] = u(F_INC, 5'd17, 4'd0);     rom[101] = u(F_INC, 5'd17, 4'd1);
    rom[102] = u(F_OP, 5'd18, 4'd2);      rom[103] = u(F_OP, 5'd19, 4'd3);
    rom[104] = u(F_INC_EOF, 5'd20, 4'd0); rom[162] = u(F_INC_EOF, 5'd1, 4'd0);
    rom[200] = u(F_OP, 5'd21, 4'd0);      rom[201] = u(F_NOP, 5'd0, 4'd0);
    rom[202] = u(F_EOF, 5'd22, 4'd0);     rom[254] = u(F_OP, 5'd23, 4'd0);
    rom[255] = u(F_NOP, 5'd0, 4'd0);

    // Directed program: CB 7C, NOP, JRNZ Z=1, JRNZ Z=0, unknown, wrap flow, INC c, LD (nn),A.
    kinds = '{2, 0, 1, 1, 6, 7, 4, 5};
    zs    = '{0, 0, 1, 0, 0, 0, 0, 0};
    new_program();
    for (int i = 0; i < 8; i++) put_instr(kinds[i], zs[i]);
    model_program();
    iReset = 1'b1;
    @(negedge iClock);
    #1;
    check("reset_outputs", {12'd0, oUopAddr, oMop, oUopValid, oIncPc, oUpdateFlags, oEof, oIrqAck, oDbgState},
          32'd0);
    check("reset_fields", {23'd0, oOp, oOperand}, 32'd0);
    @(negedge iClock);
    iReset = 1'b0;
    #1;
    check("idle_no_issue", {31'd0, oUopValid}, 32'd0);
    @(negedge iClock);
    #1;
    check("decode_mop", {23'd0, oUopValid, oMop}, {23'd0, 1'b0, 8'hCB});
    drain(1'b0, "directed");

    // Randomized programs with random stalls.
    for (int p = 0; p < 3; p++) begin
      new_program();
      for (int i = 0; i < 40; i++) put_instr($urandom_range(0, 7), 1'($urandom_range(0, 1)));
      model_program();
      start_run();
      drain(1'b1, "random");
    end

    // Interrupt dispatched at the end of INC c, then NOP.
    new_program();
    put_instr(4, 0);
    put_instr(0, 0);
    model_instr();
    model_flow(8'd200);
    model_instr();
    iIrqReq     = 1'b1;
    iIrqFlowIdx = 8'd200;
    start_run();
    wait_addr(8'd33, 1'b1, "irq");
    @(negedge iClock);
    #1;
    check("irq_ack", {31'd0, oIrqAck}, 32'd1);
    check("irq_addr", {24'd0, oUopAddr}, 32'd200);
    iIrqReq = 1'b0;
    @(negedge iClock);
    #1;
    check("irq_ack_pulse", {31'd0, oIrqAck}, 32'd0);
    drain(1'b0, "irq");

    // Three-cycle stall on uop 50 of CALL nn.
    new_program();
    put_instr(3, 0);
    model_program();
    start_run();
    wait_addr(8'd50, 1'b0, "stall");
    iStall = 1'b1;
    #2;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) begin
        @(negedge iClock);
        #3;
      end
      check("stall_hold", {18'd0, oUopAddr, oUopValid, oIncPc, oUpdateFlags, oEof, oIrqAck, 1'b0},
            {18'd0, 8'd50, 6'd0});
    end
    @(negedge iClock);
    #1;
    iStall = 1'b0;
    @(negedge iClock);
    #3;
    check("stall_resume", {24'd0, oUopAddr}, 32'd51);
    drain(1'b0, "stall");

    // Reset asserted in the middle of LD (nn),A.
    new_program();
    put_instr(5, 0);
    model_program();
    start_run();
    wait_addr(8'd102, 1'b0, "rst");
    iReset = 1'b1;
    #1;
    check("midflow_reset", {14'd0, oUopAddr, oMop, oUopValid, oIncPc, oUpdateFlags, oEof, oIrqAck, oOp == 5'd0},
          {14'd0, 8'd0, 8'd0, 5'd0, 1'b1});
    exp_q.delete();
    @(negedge iClock);
    iReset = 1'b0;
    mpc    = 8'd0;
    minstr = 0;
    model_instr();
    #1;
    check("rst_idle", {31'd0, oUopValid}, 32'd0);
    @(negedge iClock);
    #1;
    check("rst_decode", {23'd0, oUopValid, oMop}, {23'd0, 1'b0, 8'hEA});
    drain(1'b0, "rst");

    repeat (2) @(negedge iClock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
